// File: rtl/shift_deser_pkg.sv
// shift_deser_pkg
// Shared definitions for the serial-to-parallel frame receiver.
//   state_t          : receiver FSM states (PARITY is only used when the
//                      SHIFT_DESER_PARITY_EN build option is defined)
//   FRAME_START_BIT  : line level of a start bit
//   FRAME_STOP_BIT   : line level of a valid stop bit
package shift_deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic FRAME_START_BIT = 1'b0;
  localparam logic FRAME_STOP_BIT  = 1'b1;

endpackage

// File: rtl/shift_deser.sv
// shift_deser
// Serial-to-parallel frame receiver. Only cycles with ser_valid=1 advance the
// receiver. A frame is: start bit (0), DATA_W data bits LSB first, optional
// even-parity bit, stop bit (1). Good frames are presented on a valid/ready
// output; errors and overruns are reported as single-cycle pulses.
//
// Build option: SHIFT_DESER_PARITY_EN -- when defined, a parity bit follows
// the data bits and even parity over data+parity is checked.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   ser_valid  qualifies ser_bit
//   ser_bit    serial bit from the upstream shift register
//   out_data   received word, stable while out_valid=1
//   out_valid  word available
//   out_ready  consumer accepts the word when out_valid & out_ready
//   frame_err  one-cycle pulse: bad stop bit (or bad parity)
//   overrun    one-cycle pulse: good frame dropped, output still held
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_valid,
  input  logic              ser_bit,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overrun
);

  // A 1-bit word still needs a 1-bit counter.
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DATA_W-1:0]  shift_reg;
  logic [DATA_W-1:0]  out_data_reg;
  logic               out_valid_reg;
  logic               frame_err_reg;
  logic               overrun_reg;
  logic               stop_good;
  logic               out_free;

`ifdef SHIFT_DESER_PARITY_EN
  logic               pend_err_reg;
  assign stop_good = (ser_bit == FRAME_STOP_BIT) && !pend_err_reg;
`else
  assign stop_good = (ser_bit == FRAME_STOP_BIT);
`endif

  // The holding register can take a new word if empty or being drained now.
  assign out_free = !out_valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      pend_err_reg  <= 1'b0;
`endif
    end else begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;

      // Handshake completes; a load below in the same cycle overrides this.
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end

      if (ser_valid) begin
        case (state_reg)
          IDLE: begin
            if (ser_bit == FRAME_START_BIT) begin
              state_reg <= DATA;
              cnt_reg   <= '0;
`ifdef SHIFT_DESER_PARITY_EN
              pend_err_reg <= 1'b0;
`endif
            end
          end

          DATA: begin
            shift_reg[cnt_reg] <= ser_bit;
            if (cnt_reg == LAST_CNT) begin
              cnt_reg <= '0;
`ifdef SHIFT_DESER_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end

`ifdef SHIFT_DESER_PARITY_EN
          PARITY: begin
            // Even parity: XOR of all data bits and the parity bit must be 0.
            pend_err_reg <= (^shift_reg) ^ ser_bit;
            state_reg    <= STOP;
          end
`endif

          STOP: begin
            state_reg <= IDLE;
            if (!stop_good) begin
              frame_err_reg <= 1'b1;
            end else if (out_free) begin
              out_data_reg  <= shift_reg;
              out_valid_reg <= 1'b1;
            end else begin
              overrun_reg <= 1'b1;
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_shift_deser.sv
// tb_shift_deser
// Self-checking bench for shift_deser (DATA_W=8). Table-driven frame vectors,
// hand-written multi-cycle sequences, then randomized frames compared every
// cycle against a frame-level reference model built on a bit queue.
// Honours SHIFT_DESER_PARITY_EN the same way the design does.
module tb_shift_deser;

  localparam int W = 8;
`ifdef SHIFT_DESER_PARITY_EN
  localparam int FLEN = W + 3;
`else
  localparam int FLEN = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ser_valid = 1'b0;
  logic         ser_bit = 1'b1;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         frame_err;
  logic         overrun;

  int errors = 0;
  int checks = 0;

  shift_deser #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (frame level) ----------------
  bit           mq[$];
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         m_fe = 1'b0;
  logic         m_ov = 1'b0;
  bit           model_chk = 1'b0;

  task automatic model_step(input logic v, input logic b, input logic rdy, input logic rst);
    logic [W-1:0] d;
    int           ones;
    bit           good;
    bit           load;
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (rst) begin
      mq.delete();
      m_valid = 1'b0;
      m_data  = '0;
      return;
    end
    load = 1'b0;
    if (v) begin
      if (!(mq.size() == 0 && b == 1'b1)) mq.push_back(b);
      if (mq.size() == FLEN) begin
        d = '0;
        ones = 0;
        for (int i = 0; i < W; i++) begin
          d    = d + ((W)'(mq[1+i]) << i);
          ones = ones + int'(mq[1+i]);
        end
        good = (mq[FLEN-1] == 1'b1);
`ifdef SHIFT_DESER_PARITY_EN
        ones = ones + int'(mq[W+1]);
        if (ones % 2 != 0) good = 1'b0;
`endif
        mq.delete();
        if (!good)                 m_fe = 1'b1;
        else if (!m_valid || rdy)  load = 1'b1;
        else                       m_ov = 1'b1;
        if (load) m_data = d;
      end
    end
    if (load)                 m_valid = 1'b1;
    else if (m_valid && rdy)  m_valid = 1'b0;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One clock: drive, edge, then compare (outputs sampled 1 time unit after edge).
  task automatic step(input logic v, input logic b, input logic rdy, input logic rst);
    ser_valid = v;
    ser_bit   = b;
    out_ready = rdy;
    rst_n     = ~rst;
    @(posedge clk);
    #1;
    model_step(v, b, rdy, rst);
    if (model_chk)
      chk("model", {out_valid, frame_err, overrun, out_data},
                   {m_valid, m_fe, m_ov, m_data});
  endtask

  function automatic logic pick_rdy(input int rdy);
    if (rdy == 2) return logic'($urandom_range(0, 1));
    return rdy[0];
  endfunction

  // gapmode: 0 gapless, 1 one invalid cycle before every bit, 2 random 0..3 gaps.
  // rdy: 0/1 held, 2 random per cycle.
  task automatic send_frame(input logic [W-1:0] d, input logic stopb, input logic pflip,
                            input int gapmode, input int rdy);
    logic bits[FLEN];
    int   ng;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[1+i] = d[i];
`ifdef SHIFT_DESER_PARITY_EN
    bits[W+1] = (^d) ^ pflip;
`endif
    bits[FLEN-1] = stopb;
    for (int i = 0; i < FLEN; i++) begin
      ng = (gapmode == 1) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 3)) : 0;
      for (int g = 0; g < ng; g++) step(1'b0, logic'($urandom_range(0, 1)), pick_rdy(rdy), 1'b0);
      step(1'b1, bits[i], pick_rdy(rdy), 1'b0);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [W-1:0] d,
                         input logic fe, input logic ov);
    chk({name, ".valid"}, 64'(out_valid), 64'(v));
    chk({name, ".data"},  64'(out_data),  64'(d));
    chk({name, ".ferr"},  64'(frame_err), 64'(fe));
    chk({name, ".ovr"},   64'(overrun),   64'(ov));
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         stopb;
    logic         rdy;
    logic         e_valid;
    logic [W-1:0] e_data;
    logic         e_fe;
    logic         e_ov;
  } vec_t;

  vec_t tbl[5];

  initial begin
    // Expected outputs one cycle after each frame's stop bit, applied in order.
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};
    tbl[3] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    tbl[4] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk_out("reset", 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_out("idle_ones", 1'b0, '0, 1'b0, 1'b0);

    // Table-driven frames
    for (int t = 0; t < 5; t++) begin
      send_frame(tbl[t].data, tbl[t].stopb, 1'b0, 0, int'(tbl[t].rdy));
      chk_out($sformatf("vec%0d", t), tbl[t].e_valid, tbl[t].e_data, tbl[t].e_fe, tbl[t].e_ov);
    end

    // Overrun pulse lasts one cycle; held word then drained
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("ovr_one_cycle", 1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_out("drain", 1'b0, 8'h11, 1'b0, 1'b0);

    // Gapped frames give the same word as a gapless one
    send_frame(8'h5A, 1'b1, 1'b0, 0, 1);
    chk_out("gapless_5a", 1'b1, 8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1, 1);
    chk_out("toggle_5a", 1'b1, 8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 2, 1);
    chk_out("randgap_5a", 1'b1, 8'h5A, 1'b0, 1'b0);

    // Reset mid-frame clears held word and discards partial frame
    send_frame(8'hC3, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk_out("midreset0", 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk_out("midreset1", 1'b0, '0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0, 0, 0);
    chk_out("after_reset_f0", 1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk_out("f0_drained", 1'b0, 8'hF0, 1'b0, 1'b0);

`ifdef SHIFT_DESER_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0, 1);
    chk_out("par_ok_07", 1'b1, 8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 0, 1);
    chk_out("par_bad_07", 1'b0, 8'h07, 1'b1, 1'b0);
`endif

    // Randomized frames against the model, every cycle
    model_chk = 1'b1;
    for (int f = 0; f < 300; f++) begin
      int idle_n;
      idle_n = int'($urandom_range(0, 2));
      for (int k = 0; k < idle_n; k++)
        step(logic'($urandom_range(0, 1)), 1'b1, pick_rdy(2), 1'b0);
      send_frame(W'($urandom), logic'($urandom_range(0, 7) != 0),
`ifdef SHIFT_DESER_PARITY_EN
                 logic'($urandom_range(0, 7) == 0),
`else
                 1'b0,
`endif
                 int'($urandom_range(0, 2)), 2);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
    model_chk = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
